// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the serializador block.
//   ser_state_t    : FSM state encoding (IDLE, SHIFT)
//   SER_DATA_WIDTH : default parallel word width / bits per frame
// ----------------------------------------------------------------------------
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_DATA_WIDTH = 8;

endpackage : ser_pkg

// File: rtl/serializador.sv
// ----------------------------------------------------------------------------
// serializador
// Parallel-to-serial converter with a one-word holding register, MSB first.
// A word is accepted on any rising edge with valid_in=1 and ready_out=1.
// While the shifter is busy, one further word can wait in the holding
// register so that consecutive frames are emitted with no gap cycle.
//
// Ports
//   clk_100KHz  in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   data_in     in   [DATA_WIDTH] parallel word
//   valid_in    in   data_in is valid
//   ready_out   out  holding register empty (word can be accepted)
//   data_out    out  serial bit currently presented
//   write_out   out  data_out is valid; receiver samples on this edge
//   status_in   in   receiver busy: current bit is held and not counted
//   done_out    out  one-cycle pulse after the last bit of a frame
// ----------------------------------------------------------------------------
module serializador
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  write_out,
  input  logic                  status_in,
  output logic                  done_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  ser_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;

  logic transfer;
  logic last_bit;

  // Outputs derived from registered state (plus status_in for write_out).
  assign ready_out = ~hold_full_q;
  assign transfer  = valid_in & ready_out;
  assign write_out = (state_q == SHIFT) & ~status_in;
  assign data_out  = (state_q == SHIFT) ? shift_q[DATA_WIDTH-1] : 1'b0;
  assign done_out  = done_q;
  assign last_bit  = write_out & (bit_cnt_q == LAST_CNT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // status_in has no effect here; a transfer goes straight to the shifter.
        if (transfer) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (last_bit) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            // ready_out is low here, so no transfer can collide with the reload.
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
          end else if (transfer) begin
            shift_d   = data_in;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end else begin
          if (write_out) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          // Busy shifter: park the new word until the current frame ends.
          if (transfer) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
    end
  end

endmodule : serializador

// File: tb/tb_serializador.sv
// ----------------------------------------------------------------------------
// tb_serializador
// Self-checking bench for serializador: a table of single-word vectors,
// hand-written multi-cycle sequences, and a randomized run checked against a
// word-queue reference model (two-deep buffer of pending frames).
// ----------------------------------------------------------------------------
module tb_serializador;

  localparam int DW = 8;

  logic          clk_100KHz;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          data_out;
  logic          write_out;
  logic          status_in;
  logic          done_out;

  serializador #(.DATA_WIDTH(DW)) dut (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .write_out  (write_out),
    .status_in  (status_in),
    .done_out   (done_out)
  );

  initial clk_100KHz = 1'b0;
  always #5 clk_100KHz = ~clk_100KHz;

  // Counters
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: words accepted but not yet fully sent, and position of
  // the next bit within the front word.
  logic [DW-1:0] mq[$];
  int            mpos  = 0;
  bit            mdone = 1'b0;
  logic          m_ready, m_write, m_dout, m_done;

  // Sampled DUT outputs from the latest cycle and stream collectors.
  logic          s_ready, s_write, s_dout, s_done;
  logic [31:0]   ser_bits;
  int            wcount;
  int            dcount;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_outputs();
    if (reset) begin
      m_ready = 1'b1; m_write = 1'b0; m_dout = 1'b0; m_done = 1'b0;
    end else begin
      m_ready = (mq.size() < 2);
      m_write = (mq.size() > 0) && !status_in;
      m_dout  = (mq.size() > 0) ? mq[0][DW-1-mpos] : 1'b0;
      m_done  = mdone;
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic s,
                              input logic [DW-1:0] d);
    bit acc;
    if (r) begin
      mq.delete();
      mpos  = 0;
      mdone = 1'b0;
    end else begin
      acc   = v && (mq.size() < 2);
      mdone = 1'b0;
      if (mq.size() > 0 && !s) begin
        if (mpos == DW-1) begin
          void'(mq.pop_front());
          mpos  = 0;
          mdone = 1'b1;
        end else begin
          mpos++;
        end
      end
      if (acc) mq.push_back(d);
    end
  endtask

  task automatic clear_collect();
    ser_bits = '0;
    wcount   = 0;
    dcount   = 0;
  endtask

  // One clock cycle: drive inputs, sample and check against the model on the
  // falling edge, then advance the model on the rising edge.
  task automatic tick(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic s);
    reset = r; valid_in = v; data_in = d; status_in = s;
    @(negedge clk_100KHz);
    model_outputs();
    s_ready = ready_out; s_write = write_out; s_dout = data_out; s_done = done_out;
    check("ready_out", int'(s_ready), int'(m_ready));
    check("write_out", int'(s_write), int'(m_write));
    check("data_out",  int'(s_dout),  int'(m_dout));
    check("done_out",  int'(s_done),  int'(m_done));
    if (s_write) begin
      ser_bits = {ser_bits[30:0], s_dout};
      wcount++;
    end
    if (s_done) dcount++;
    @(posedge clk_100KHz);
    model_update(r, v, s, d);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] din;
    logic          sts;
    logic          e_rdy;
    logic          e_wr;
    logic          e_dout;
    logic          e_done;
  } vec_t;

  vec_t tbl[12];

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; status_in = 1'b0;
    clear_collect();
    #1;

    // ---------------- Table: reset state, then single word 0xA5 ------------
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].sts);
      check($sformatf("tbl%0d_ready", i), int'(s_ready), int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_write", i), int'(s_write), int'(tbl[i].e_wr));
      check($sformatf("tbl%0d_dout",  i), int'(s_dout),  int'(tbl[i].e_dout));
      check($sformatf("tbl%0d_done",  i), int'(s_done),  int'(tbl[i].e_done));
    end
    $display("[TB] table single-word 0xA5 applied");

    // ---------------- Back-to-back 0x3C then 0xF0 ---------------------------
    idle(2);
    tick(1'b0, 1'b1, 8'h3C, 1'b0);
    clear_collect();
    tick(1'b0, 1'b1, 8'hF0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("b2b_ready_drop", int'(s_ready), 0);
    idle(15);
    check("b2b_writes", wcount, 16);
    check("b2b_bits", int'(ser_bits[15:0]), 16'h3CF0);
    check("b2b_done_pulses", dcount, 2);
    $display("[TB] back-to-back 0x3C,0xF0 bits=%04h", ser_bits[15:0]);

    // ---------------- Stall during 0x81 -------------------------------------
    idle(2);
    tick(1'b0, 1'b1, 8'h81, 1'b0);
    clear_collect();
    idle(2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(6);
    check("stall_no_early_done", dcount, 0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("stall_done_at_12", int'(s_done), 1);
    check("stall_writes", wcount, 8);
    check("stall_bits", int'(ser_bits[7:0]), 8'h81);
    $display("[TB] stall 0x81 bits=%02h writes=%0d", ser_bits[7:0], wcount);

    // ---------------- Full hold: 0x55 waits for ready_out -------------------
    begin
      int n;
      idle(2);
      tick(1'b0, 1'b1, 8'h3C, 1'b0);
      clear_collect();
      tick(1'b0, 1'b1, 8'h11, 1'b0);
      for (n = 0; n < 20; n++) begin
        tick(1'b0, 1'b1, 8'h55, 1'b0);
        if (s_ready) break;
      end
      check("hold_wait_cycles", n + 1, 8);
      idle(17);
      check("hold_writes", wcount, 24);
      check("hold_bits", int'(ser_bits[23:0]), 24'h3C1155);
      $display("[TB] full-hold 0x55 accepted after %0d cycles", n + 1);
    end

    // ---------------- Reset mid-frame with hold full ------------------------
    idle(2);
    tick(1'b0, 1'b1, 8'hFF, 1'b0);
    tick(1'b0, 1'b1, 8'h77, 1'b0);
    idle(3);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_write", int'(s_write), 0);
    check("rst_dout",  int'(s_dout),  0);
    check("rst_done",  int'(s_done),  0);
    clear_collect();
    idle(2);
    tick(1'b0, 1'b1, 8'h01, 1'b0);
    idle(10);
    check("rst_no_stale", wcount, 8);
    check("rst_new_bits", int'(ser_bits[7:0]), 8'h01);
    check("rst_new_done", dcount, 1);
    $display("[TB] reset mid-frame, then 0x01 bits=%02h", ser_bits[7:0]);

    // ---------------- Randomized run against the model ----------------------
    for (int i = 0; i < 3000; i++) begin
      logic r, v, s;
      logic [DW-1:0] d;
      r = ($urandom_range(0, 249) == 0);
      v = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 3) == 0);
      d = DW'($urandom);
      tick(r, v, d, s);
    end
    idle(4);
    $display("[TB] random run finished");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serializador
